// File: rtl/tap_step_bank_ctrl.sv
// tap_step_bank_ctrl
// Multi-channel tap-step bank with a get/set command decoder. A rising edge
// on inputCmdTrigger starts a command that completes three edges later with
// a one-cycle cmdDone pulse, plus cmdErr when the command was rejected.
//
// Ports:
//   clk             system clock, sole domain
//   rest            synchronous active-high reset
//   inputCmd        32-bit command word, sampled in the trigger-rise cycle
//   inputCmdTrigger command strobe, rising edge starts a command
//   overDec         live per-channel over-range level (CH_N bits)
//   tapStep         packed tap steps, channel c at [c*TAP_W +: TAP_W]
//   outputValue     read-back data of the most recent get
//   cmdBusy         high while a command is in flight
//   cmdDone         one-cycle completion pulse
//   cmdErr          one-cycle reject pulse, coincident with cmdDone
module tap_step_bank_ctrl #(
  parameter int CH_N    = 4,
  parameter int TAP_W   = 4,
  parameter int TAP_RST = 0
) (
  input  logic                    clk,
  input  logic                    rest,
  input  logic [31:0]             inputCmd,
  input  logic                    inputCmdTrigger,
  input  logic [CH_N-1:0]         overDec,
  output logic [CH_N*TAP_W-1:0]   tapStep,
  output logic [31:0]             outputValue,
  output logic                    cmdBusy,
  output logic                    cmdDone,
  output logic                    cmdErr
);

  typedef enum logic [2:0] {IDLE, DECODE, GET, SET, ERR} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [31:0]             cmd_q;
  logic                    trig_d;
  logic [CH_N-1:0]         over_d;
  logic [CH_N-1:0]         sticky;
  logic [CH_N-1:0]         sticky_next;
  logic [CH_N-1:0]         clr_mask;
  logic [CH_N*TAP_W-1:0]   tap_q;
  logic [31:0]             out_q;
  logic                    done_q;
  logic                    err_q;
  logic                    rise;
  logic [3:0]              opcode;
  logic [3:0]              sel;
  logic [7:0]              ch;
  logic [15:0]             data;
  logic [31:0]             data_ext;
  logic                    ch_ok;
  logic                    get_ok;
  logic                    set_ok;
  logic [TAP_W-1:0]        tap_sel;
  logic                    sticky_sel;
  logic                    over_sel;
  logic [31:0]             get_value;

  assign rise     = inputCmdTrigger & ~trig_d;
  assign opcode   = cmd_q[31:28];
  assign sel      = cmd_q[27:24];
  assign ch       = cmd_q[23:16];
  assign data     = cmd_q[15:0];
  // Zero-extend so the W1C mask can be sliced for any CH_N up to 32.
  assign data_ext = {16'h0000, data};
  assign ch_ok    = (ch < 8'(CH_N));

  // sel 2 and sel 3 gets ignore ch; only per-channel access needs range check.
  assign get_ok = (opcode == 4'd6) &&
                  (((sel == 4'd1) && ch_ok) || (sel == 4'd2) || (sel == 4'd3));
  assign set_ok = (opcode == 4'd7) &&
                  (((sel == 4'd1) && ch_ok) || (sel == 4'd2));

  // State register.
  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a rise outside IDLE is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = DECODE;
      DECODE: begin
        if (get_ok)      state_next = GET;
        else if (set_ok) state_next = SET;
        else             state_next = ERR;
      end
      GET, SET, ERR: state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // Pick the addressed channel's fields for a sel 1 get.
  always_comb begin
    tap_sel    = '0;
    sticky_sel = 1'b0;
    over_sel   = 1'b0;
    for (int c = 0; c < CH_N; c++) begin
      if (8'(c) == ch) begin
        tap_sel    = tap_q[c*TAP_W +: TAP_W];
        sticky_sel = sticky[c];
        over_sel   = over_d[c];
      end
    end
  end

  always_comb begin
    get_value = '0;
    case (sel)
      4'd1:    get_value = 32'({sticky_sel, over_sel, tap_sel});
      4'd2:    get_value = 32'(sticky);
      4'd3:    get_value = {8'h54, 8'(CH_N), 8'(TAP_W), 8'h01};
      default: get_value = '0;
    endcase
  end

  // Set is ORed in after the clear so a simultaneous over-range wins.
  always_comb begin
    clr_mask = '0;
    if ((state == SET) && (sel == 4'd2)) clr_mask = data_ext[CH_N-1:0];
    sticky_next = (sticky & ~clr_mask) | over_d;
  end

  // Datapath: command capture, sticky flags, tap bank and completion pulses.
  always_ff @(posedge clk) begin
    if (rest) begin
      trig_d <= 1'b0;
      over_d <= '0;
      sticky <= '0;
      cmd_q  <= '0;
      tap_q  <= {CH_N{TAP_W'(TAP_RST)}};
      out_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      trig_d <= inputCmdTrigger;
      over_d <= overDec;
      sticky <= sticky_next;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if ((state == IDLE) && rise) cmd_q <= inputCmd;
      case (state)
        GET: begin
          out_q  <= get_value;
          done_q <= 1'b1;
        end
        SET: begin
          if (sel == 4'd1) begin
            for (int c = 0; c < CH_N; c++) begin
              if (8'(c) == ch) tap_q[c*TAP_W +: TAP_W] <= data[TAP_W-1:0];
            end
          end
          done_q <= 1'b1;
        end
        ERR: begin
          if (opcode == 4'd6) out_q <= 32'hA55A_AA55;
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tapStep     = tap_q;
  assign outputValue = out_q;
  assign cmdBusy     = (state != IDLE);
  assign cmdDone     = done_q;
  assign cmdErr      = err_q;

endmodule

// File: tb/tb_tap_step_bank_ctrl.sv
// tb_tap_step_bank_ctrl
// Bench for tap_step_bank_ctrl with CH_N = 4, TAP_W = 4, TAP_RST = 3.
// Directed scenarios plus randomized commands checked against a
// behavioural model of the tap bank, sticky flags and read-back register.
module tb_tap_step_bank_ctrl;

  localparam int CH_N    = 4;
  localparam int TAP_W   = 4;
  localparam int TAP_RST = 3;

  logic                  clk = 1'b0;
  logic                  rest;
  logic [31:0]           inputCmd;
  logic                  inputCmdTrigger;
  logic [CH_N-1:0]       overDec;
  logic [CH_N*TAP_W-1:0] tapStep;
  logic [31:0]           outputValue;
  logic                  cmdBusy;
  logic                  cmdDone;
  logic                  cmdErr;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state.
  logic [3:0]  tap_m [CH_N];
  logic [3:0]  sticky_m;
  logic [3:0]  overd_m;
  logic [31:0] out_m;

  tap_step_bank_ctrl #(.CH_N(CH_N), .TAP_W(TAP_W), .TAP_RST(TAP_RST)) dut (
    .clk(clk), .rest(rest), .inputCmd(inputCmd), .inputCmdTrigger(inputCmdTrigger),
    .overDec(overDec), .tapStep(tapStep), .outputValue(outputValue),
    .cmdBusy(cmdBusy), .cmdDone(cmdDone), .cmdErr(cmdErr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] taps_packed();
    return {tap_m[3], tap_m[2], tap_m[1], tap_m[0]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH_N; c++) tap_m[c] = 4'(TAP_RST);
    sticky_m = '0;
    overd_m  = '0;
    out_m    = '0;
  endtask

  // Apply overDec and wait until it has reached the sticky flags.
  task automatic settle(input logic [3:0] ov);
    @(negedge clk);
    overDec = ov;
    repeat (3) @(negedge clk);
    overd_m  = ov;
    sticky_m = sticky_m | ov;
  endtask

  // Command semantics expressed directly from the field rules.
  task automatic predict(input logic [31:0] cmd, output bit exp_err);
    logic [3:0] op;
    logic [3:0] s;
    int         chn;
    logic [15:0] d;
    op = cmd[31:28]; s = cmd[27:24]; chn = int'(cmd[23:16]); d = cmd[15:0];
    exp_err = 1'b0;
    if (op == 4'd6 && s == 4'd1 && chn < CH_N)
      out_m = {26'd0, sticky_m[chn], overd_m[chn], tap_m[chn]};
    else if (op == 4'd6 && s == 4'd2)
      out_m = {28'd0, sticky_m};
    else if (op == 4'd6 && s == 4'd3)
      out_m = 32'h5404_0401;
    else if (op == 4'd7 && s == 4'd1 && chn < CH_N)
      tap_m[chn] = d[3:0];
    else if (op == 4'd7 && s == 4'd2)
      sticky_m = (sticky_m & ~d[3:0]) | overd_m;
    else begin
      exp_err = 1'b1;
      if (op == 4'd6) out_m = 32'hA55A_AA55;
    end
  endtask

  // Drive one command and observe 8 following cycles.
  task automatic issue(input logic [31:0] cmd, output int dones, output int errs,
                       output int first);
    dones = 0; errs = 0; first = -1;
    @(negedge clk);
    inputCmd = cmd;
    inputCmdTrigger = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cmdDone) begin
        dones++;
        if (first < 0) first = i;
      end
      if (cmdErr) errs++;
      if (i == 1) begin
        inputCmdTrigger = 1'b0;
        inputCmd = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    rest = 1'b1; inputCmdTrigger = 1'b0; inputCmd = '0; overDec = '0;
    repeat (3) @(negedge clk);
    model_reset();
    compared++; if (tapStep !== 16'h3333) begin mismatched++; $display("[TB] FAIL reset_taps: got %h expected %h", tapStep, 16'h3333); end
    compared++; if (outputValue !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out: got %h expected %h", outputValue, 32'h0); end
    compared++; if ({cmdBusy, cmdDone, cmdErr} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {cmdBusy, cmdDone, cmdErr}); end
    rest = 1'b0;
  endtask

  task automatic test_set_get();
    int d, e, f; bit x;
    predict(32'h7102_0009, x);
    issue(32'h7102_0009, d, e, f);
    compared++; if (d !== 1) begin mismatched++; $display("[TB] FAIL set_done_count: got %0d expected 1", d); end
    compared++; if (f !== 3) begin mismatched++; $display("[TB] FAIL set_latency: got %0d expected 3", f); end
    compared++; if (e !== 0) begin mismatched++; $display("[TB] FAIL set_err: got %0d expected 0", e); end
    compared++; if (tapStep !== 16'h3933) begin mismatched++; $display("[TB] FAIL set_taps: got %h expected %h", tapStep, 16'h3933); end
    settle(4'b0100);
    predict(32'h6102_0000, x);
    issue(32'h6102_0000, d, e, f);
    compared++; if (outputValue !== 32'h39) begin mismatched++; $display("[TB] FAIL get_ch2: got %h expected %h", outputValue, 32'h39); end
    compared++; if (d !== 1) begin mismatched++; $display("[TB] FAIL get_done_count: got %0d expected 1", d); end
  endtask

  task automatic test_sticky_w1c();
    int d, e, f; bit x;
    predict(32'h7200_0004, x);
    issue(32'h7200_0004, d, e, f);
    compared++; if (outputValue !== 32'h39) begin mismatched++; $display("[TB] FAIL set_keeps_out: got %h expected %h", outputValue, 32'h39); end
    predict(32'h6200_0000, x);
    issue(32'h6200_0000, d, e, f);
    compared++; if (outputValue !== 32'h4) begin mismatched++; $display("[TB] FAIL w1c_set_wins: got %h expected %h", outputValue, 32'h4); end
    settle(4'b0000);
    predict(32'h7200_0004, x);
    issue(32'h7200_0004, d, e, f);
    predict(32'h6200_0000, x);
    issue(32'h6200_0000, d, e, f);
    compared++; if (outputValue !== 32'h0) begin mismatched++; $display("[TB] FAIL w1c_cleared: got %h expected %h", outputValue, 32'h0); end
  endtask

  task automatic test_errors();
    int d, e, f; bit x;
    predict(32'h3000_0000, x);
    issue(32'h3000_0000, d, e, f);
    compared++; if ({d, e} !== {32'd1, 32'd1}) begin mismatched++; $display("[TB] FAIL bad_opcode_pulses: got done=%0d err=%0d expected 1/1", d, e); end
    compared++; if (outputValue !== 32'h0 || tapStep !== 16'h3933) begin mismatched++; $display("[TB] FAIL bad_opcode_state: got out=%h taps=%h expected 0/3933", outputValue, tapStep); end
    predict(32'h6107_0000, x);
    issue(32'h6107_0000, d, e, f);
    compared++; if (outputValue !== 32'hA55A_AA55) begin mismatched++; $display("[TB] FAIL get_bad_ch: got %h expected %h", outputValue, 32'hA55A_AA55); end
    compared++; if (e !== 1) begin mismatched++; $display("[TB] FAIL get_bad_ch_err: got %0d expected 1", e); end
    predict(32'h7107_0005, x);
    issue(32'h7107_0005, d, e, f);
    compared++; if (tapStep !== 16'h3933 || e !== 1) begin mismatched++; $display("[TB] FAIL set_bad_ch: got taps=%h err=%0d expected 3933/1", tapStep, e); end
    predict(32'h6103_0000, x);
    issue(32'h6103_0000, d, e, f);
    compared++; if (outputValue !== 32'h3 || e !== 0) begin mismatched++; $display("[TB] FAIL get_last_ch: got out=%h err=%0d expected 3/0", outputValue, e); end
    predict(32'h7300_0000, x);
    issue(32'h7300_0000, d, e, f);
    compared++; if (e !== 1) begin mismatched++; $display("[TB] FAIL set_sel3_err: got %0d expected 1", e); end
  endtask

  task automatic test_busy();
    int dones = 0;
    @(negedge clk);
    inputCmd = 32'h7101_0005; inputCmdTrigger = 1'b1;
    @(negedge clk);
    inputCmdTrigger = 1'b0; inputCmd = 32'h7100_0006;
    compared++; if (cmdBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_high: got %b expected 1", cmdBusy); end
    @(negedge clk);
    inputCmdTrigger = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmdDone) dones++;
    end
    inputCmdTrigger = 1'b0;
    tap_m[1] = 4'h5;
    compared++; if (dones !== 1) begin mismatched++; $display("[TB] FAIL busy_done_count: got %0d expected 1", dones); end
    compared++; if (tapStep !== taps_packed()) begin mismatched++; $display("[TB] FAIL busy_taps: got %h expected %h", tapStep, taps_packed()); end
  endtask

  task automatic test_held();
    int dones = 0;
    @(negedge clk);
    inputCmd = 32'h7103_0007; inputCmdTrigger = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmdDone) dones++;
    end
    inputCmdTrigger = 1'b0;
    tap_m[3] = 4'h7;
    compared++; if (dones !== 1) begin mismatched++; $display("[TB] FAIL held_done_count: got %0d expected 1", dones); end
    compared++; if (tapStep !== taps_packed()) begin mismatched++; $display("[TB] FAIL held_taps: got %h expected %h", tapStep, taps_packed()); end
  endtask

  task automatic test_back_to_back();
    int dones = 0; bit x;
    @(negedge clk);
    inputCmd = 32'h7100_0002; inputCmdTrigger = 1'b1;
    @(negedge clk);
    inputCmdTrigger = 1'b0;
    if (cmdDone) dones++;
    @(negedge clk);
    if (cmdDone) dones++;
    @(negedge clk);
    if (cmdDone) dones++;
    inputCmd = 32'h6100_0000; inputCmdTrigger = 1'b1;
    predict(32'h7100_0002, x);
    predict(32'h6100_0000, x);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmdDone) dones++;
      inputCmdTrigger = 1'b0;
    end
    compared++; if (dones !== 2) begin mismatched++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", dones); end
    compared++; if (outputValue !== out_m) begin mismatched++; $display("[TB] FAIL b2b_out: got %h expected %h", outputValue, out_m); end
  endtask

  task automatic test_reset_decode();
    int dones = 0; int d, e, f; bit x;
    @(negedge clk);
    inputCmd = 32'h7100_0009; inputCmdTrigger = 1'b1;
    @(negedge clk);
    inputCmdTrigger = 1'b0; rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmdDone) dones++;
    end
    compared++; if (dones !== 0) begin mismatched++; $display("[TB] FAIL abort_done: got %0d expected 0", dones); end
    compared++; if (cmdBusy !== 1'b0 || tapStep !== 16'h3333) begin mismatched++; $display("[TB] FAIL abort_state: got busy=%b taps=%h expected 0/3333", cmdBusy, tapStep); end
    predict(32'h6300_0000, x);
    issue(32'h6300_0000, d, e, f);
    compared++; if (outputValue !== 32'h5404_0401) begin mismatched++; $display("[TB] FAIL param_id: got %h expected %h", outputValue, 32'h5404_0401); end
  endtask

  task automatic test_random();
    int d, e, f; bit exp_err;
    logic [3:0] ops [6];
    logic [31:0] cmd;
    ops[0] = 4'd6; ops[1] = 4'd7; ops[2] = 4'd6; ops[3] = 4'd7; ops[4] = 4'd3; ops[5] = 4'hF;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) settle(4'($urandom_range(0, 15)));
      cmd = {ops[$urandom_range(0, 5)], 4'($urandom_range(0, 4)),
             8'($urandom_range(0, 5)), 16'($urandom)};
      predict(cmd, exp_err);
      issue(cmd, d, e, f);
      compared++; if (d !== 1 || f !== 3) begin mismatched++; $display("[TB] FAIL rnd_done cmd=%h: got count=%0d at=%0d expected 1 at 3", cmd, d, f); end
      compared++; if (e !== int'(exp_err)) begin mismatched++; $display("[TB] FAIL rnd_err cmd=%h: got %0d expected %0d", cmd, e, exp_err); end
      compared++; if (outputValue !== out_m) begin mismatched++; $display("[TB] FAIL rnd_out cmd=%h: got %h expected %h", cmd, outputValue, out_m); end
      compared++; if (tapStep !== taps_packed()) begin mismatched++; $display("[TB] FAIL rnd_taps cmd=%h: got %h expected %h", cmd, tapStep, taps_packed()); end
    end
  endtask

  initial begin
    test_reset();
    test_set_get();
    test_sticky_w1c();
    test_errors();
    test_busy();
    test_held();
    test_back_to_back();
    test_reset_decode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
